rvm_bitwise_arb: RTL
====================

Name: rvm_bitwise_arb

Overview:
- Shares one rvm_bitwise instance between two requesters: port 0 (execute stage) and port 1 (CSR/atomic helper).
- Round-robin arbitration, operand capture, sequencing of the bitwise unit, and a registered response with valid/ready handshake.
- Sits between the multi-cycle control FSM and the bitwise datapath.
- Holds the bitwise unit at NOP whenever it is idle, so its inputs stay isolated.

Parameters:
- CNT_W, 16, width of per-requester grant counters (used only with RVM_BITWISE_ARB_STATS_EN).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  3  RVM_BITWISE_* opcode
- req0_lhs  in  32  left operand
- req0_rhs  in  32  right operand
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_result  out  32  result to requester 0
- req1_valid/req1_ready/req1_op/req1_lhs/req1_rhs  as port 0, requester 1
- rsp1_valid/rsp1_ready/rsp1_result  as port 0, requester 1
- bw_op  out  3  to rvm_bitwise op
- bw_lhs  out  32  to rvm_bitwise lhs
- bw_rhs  out  32  to rvm_bitwise rhs
- bw_valid  in  1  from rvm_bitwise valid
- bw_result  in  32  from rvm_bitwise result
- grant0_cnt  out  CNT_W  grants to requester 0 (STATS_EN only)
- grant1_cnt  out  CNT_W  grants to requester 1 (STATS_EN only)

Behaviour:
- Single clock clk; reset is asynchronous and active-low on resetn.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: all outputs 0; bw_op = RVM_BITWISE_NOP; captured op/lhs/rhs/result registers 0; grant owner 0; rr pointer favours requester 0.
- IDLE:
  - If any reqN_valid, grant one requester: reqN_ready=1 combinationally for that requester only, in the same cycle.
  - Capture op, lhs, rhs and owner on the clock edge, then go to EXEC.
  - If both are valid, the requester that did not win the last grant wins. After reset, requester 0 wins.
  - If only one is valid, it wins regardless of the pointer.
  - Pointer updates only on a grant.
- reqN_ready is 0 in EXEC and RESP. Requests held during those states wait; valid must stay asserted until ready.
- EXEC:
  - bw_op/bw_lhs/bw_rhs are driven from the captured registers.
  - Result register loads bw_result if bw_valid=1, else 0.
  - Always goes to RESP after one cycle.
- Outside EXEC: bw_op = NOP and bw_lhs = bw_rhs = 0.
- RESP:
  - rspN_valid=1 for the owner only; rspN_result = result register. The non-owner's rsp_valid is 0.
  - Held stable until rspN_ready=1, then IDLE next cycle.
  - The non-owner's rsp_ready is ignored.
- Latency: request accepted at edge T; rsp_valid high in cycle T+2. With rsp_ready tied high, next accept is at T+3, giving 1 op per 3 cycles.
- NOP (0) or undefined opcode (4..7): accepted and sequenced normally; result 0.
- rsp_result is undefined outside rsp_valid but is held at last value; the bench checks it only with valid.
- Reset asserted mid-operation: FSM to IDLE immediately, pending result discarded, no response issued, pointer reset.
- No combinational path from rsp_ready to req_ready.

Optional Feature:
- Macro: RVM_BITWISE_ARB_STATS_EN.
- Defined:
  - grant0_cnt/grant1_cnt present.
  - Each increments by 1 on its requester's grant (req_valid & req_ready) and saturates at all-ones.
  - Reset to 0.
- Undefined: counter ports and logic absent; behaviour otherwise identical.

Decomposition:
- Opcode constants RVM_BITWISE_NOP/OR/AND/XOR live in rvm_constants.v.
- New FSM state encodings also go in rvm_constants.v: RVM_BWARB_IDLE=2'd0, RVM_BWARB_EXEC=2'd1, RVM_BWARB_RESP=2'd2.
- One natural sub-module: rvm_rr_arb2 (2-way round-robin grant plus pointer), reusable by other shared units.
- rvm_bitwise is instantiated by the parent, not inside this block.

Test Plan:
- Req0 OR lhs=0x0F0F0000 rhs=0x000000FF, rsp0_ready=1 -> ready at T, bw_op=OR at T+1, rsp0_valid at T+2 with 0x0F0F00FF, rsp1_valid=0 throughout.
- Both valid at T after reset: req0 AND 0xFFFF0000/0x0FF00FF0, req1 XOR 0xAAAAAAAA/0xFFFFFFFF -> req0 granted first, result 0x0FF00000; then req1 granted, result 0x55555555.
- Backpressure: rsp1_ready=0 for 5 cycles -> rsp1_valid and rsp1_result stable, req0_ready=0 for those cycles, IDLE reached the cycle after rsp1_ready=1.
- Opcode 0 and opcode 6 with nonzero operands -> accepted, result 0, bw_op=NOP at EXEC.
- resetn low during EXEC -> rsp valids stay 0, bw_op=NOP immediately, next grant after release goes to req0.
- STATS_EN: 3 grants to req0, 2 to req1 -> counters 3/2; CNT_W=2 with 5 req0 grants -> grant0_cnt saturates at 3.

Source files
------------

// File: rtl/rvm_bitwise_arb_pkg.sv
// Shared constants and types for the rvm_bitwise arbiter: bitwise opcodes,
// arbiter FSM encodings and the captured command record.
package rvm_bitwise_arb_pkg;

  localparam logic [2:0] RVM_BITWISE_NOP = 3'd0;
  localparam logic [2:0] RVM_BITWISE_OR  = 3'd1;
  localparam logic [2:0] RVM_BITWISE_AND = 3'd2;
  localparam logic [2:0] RVM_BITWISE_XOR = 3'd3;

  localparam logic [1:0] RVM_BWARB_IDLE = 2'd0;
  localparam logic [1:0] RVM_BWARB_EXEC = 2'd1;
  localparam logic [1:0] RVM_BWARB_RESP = 2'd2;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
  } bw_cmd_t;

  // Opcodes 4..7 have no meaning for the bitwise unit and are sequenced as NOP.
  function automatic logic [2:0] bw_legal_op(input logic [2:0] op);
    return (op > RVM_BITWISE_XOR) ? RVM_BITWISE_NOP : op;
  endfunction

endpackage

// File: rtl/rvm_bitwise_arb_if.sv
// Request/response handshakes of both requesters plus the link to the shared
// rvm_bitwise unit. slave = arbiter side, master = requesters and bitwise unit.
interface rvm_bitwise_arb_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_lhs;
  logic [31:0] req0_rhs;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_result;

  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [31:0] req1_lhs;
  logic [31:0] req1_rhs;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_result;

  logic [2:0]  bw_op;
  logic [31:0] bw_lhs;
  logic [31:0] bw_rhs;
  logic        bw_valid;
  logic [31:0] bw_result;

  modport slave (
    input  req0_valid, req0_op, req0_lhs, req0_rhs, rsp0_ready,
    input  req1_valid, req1_op, req1_lhs, req1_rhs, rsp1_ready,
    input  bw_valid, bw_result,
    output req0_ready, rsp0_valid, rsp0_result,
    output req1_ready, rsp1_valid, rsp1_result,
    output bw_op, bw_lhs, bw_rhs
  );

  modport master (
    output req0_valid, req0_op, req0_lhs, req0_rhs, rsp0_ready,
    output req1_valid, req1_op, req1_lhs, req1_rhs, rsp1_ready,
    output bw_valid, bw_result,
    input  req0_ready, rsp0_valid, rsp0_result,
    input  req1_ready, rsp1_valid, rsp1_result,
    input  bw_op, bw_lhs, bw_rhs
  );

endinterface

// File: rtl/rvm_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant while enabled, and a pointer that
// favours whichever requester did not win the previous grant.
module rvm_rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio1;

  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio1 ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio1 <= 1'b0;
    end else if (|gnt) begin
      prio1 <= gnt[0];
    end
  end

endmodule

// File: rtl/rvm_bitwise_arb.sv
// Shares one rvm_bitwise unit between two requesters (IDLE/EXEC/RESP sequencer).
// Optional grant counters are built when RVM_BITWISE_ARB_STATS_EN is defined.
module rvm_bitwise_arb
  import rvm_bitwise_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
`ifdef RVM_BITWISE_ARB_STATS_EN
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt,
`endif
  rvm_bitwise_arb_if.slave bus
);

  logic [1:0]  state;
  logic        owner;
  bw_cmd_t     cmd;
  bw_cmd_t     sel_cmd;
  logic [31:0] result;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        in_idle;
  logic        in_exec;
  logic        in_resp;
  logic        rsp_done;

  assign in_idle = (state == RVM_BWARB_IDLE);
  assign in_exec = (state == RVM_BWARB_EXEC);
  assign in_resp = (state == RVM_BWARB_RESP);
  assign req     = {bus.req1_valid, bus.req0_valid};

  rvm_rr_arb2 u_rr (
    .clk    (clk),
    .resetn (resetn),
    .en     (in_idle),
    .req    (req),
    .gnt    (gnt)
  );

  always_comb begin
    sel_cmd = '0;
    if (gnt[1]) begin
      sel_cmd.op  = bw_legal_op(bus.req1_op);
      sel_cmd.lhs = bus.req1_lhs;
      sel_cmd.rhs = bus.req1_rhs;
    end else begin
      sel_cmd.op  = bw_legal_op(bus.req0_op);
      sel_cmd.lhs = bus.req0_lhs;
      sel_cmd.rhs = bus.req0_rhs;
    end
  end

  // Only the owner's rsp_ready can release the response.
  assign rsp_done = owner ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= RVM_BWARB_IDLE;
      owner  <= 1'b0;
      cmd    <= '0;
      result <= '0;
    end else begin
      case (state)
        RVM_BWARB_IDLE: begin
          if (|gnt) begin
            cmd   <= sel_cmd;
            owner <= gnt[1];
            state <= RVM_BWARB_EXEC;
          end
        end
        RVM_BWARB_EXEC: begin
          result <= bus.bw_valid ? bus.bw_result : '0;
          state  <= RVM_BWARB_RESP;
        end
        RVM_BWARB_RESP: begin
          if (rsp_done) begin
            state <= RVM_BWARB_IDLE;
          end
        end
        default: state <= RVM_BWARB_IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = gnt[0];
  assign bus.req1_ready  = gnt[1];
  assign bus.rsp0_valid  = in_resp & ~owner;
  assign bus.rsp1_valid  = in_resp & owner;
  assign bus.rsp0_result = result;
  assign bus.rsp1_result = result;

  assign bus.bw_op  = in_exec ? cmd.op  : RVM_BITWISE_NOP;
  assign bus.bw_lhs = in_exec ? cmd.lhs : '0;
  assign bus.bw_rhs = in_exec ? cmd.rhs : '0;

`ifdef RVM_BITWISE_ARB_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else begin
      if (gnt[0] && !(&grant0_cnt)) begin
        grant0_cnt <= grant0_cnt + 1'b1;
      end
      if (gnt[1] && !(&grant1_cnt)) begin
        grant1_cnt <= grant1_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule
